instr_fetch: RTL



---
 rtl/instr_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
//============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Addresses the program ROM from a
//               program counter, captures {pc, word} pairs into a small
//               FIFO and presents them to decode over a valid/ready
//               handshake. Branch/jump redirects flush in-flight words and
//               reload the PC.
// Revision    : 1.0 - initial release
//============================================================================
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready
);

    // Pointer width indexes DEPTH entries; count width must reach DEPTH
    // itself, so it needs one more state than the pointers.
    localparam int              c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
    localparam logic [c_AW-1:0] c_PINC  = c_AW'(1);

    // Architectural state
    logic [15:0]     r_pc;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    // FIFO storage: fetch address and instruction word per entry
    logic [15:0]     r_mem_pc   [DEPTH];
    logic [15:0]     r_mem_word [DEPTH];

    // Handshake / flow-control terms
    logic            w_pop;
    logic            w_space;
    logic            w_push;
    logic [c_CW-1:0] w_count_nxt;

    // The ROM is addressed straight from the PC register
    assign rom_addr = r_pc;

    // A head word accepted by decode counts even when a redirect flushes
    // the FIFO in the same cycle; a pop also frees a slot for this cycle's
    // fetch so a full FIFO streams without a bubble.
    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid & instr_ready;
    assign w_space     = (r_count < c_DEPTH) | w_pop;
    assign w_push      = w_space & ~redirect_valid;

    // Head presentation: forced to zero when empty so decode never sees
    // stale storage contents.
    assign instr    = instr_valid ? r_mem_word[r_rd_ptr] : 16'h0000;
    assign instr_pc = instr_valid ? r_mem_pc[r_rd_ptr]   : 16'h0000;

    // Occupancy after this cycle's push/pop (ignoring redirect flush)
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // PC, pointers and occupancy; redirect wins over normal fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 16'h0001;
                r_wr_ptr <= r_wr_ptr + c_PINC;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PINC;
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO write port; contents are don't-care until count says otherwise
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_pc;
            r_mem_word[r_wr_ptr] <= rom_data;
        end
    end

endmodule
`default_nettype wire
